pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Every cycle it decides which of the four pipeline register bars (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC capture, hold, or load a bubble. Its inputs are cache hit status, load-use hazards, control transfers resolved in MEM, and halt progress. It sits beside the datapath and drives the pipeline register enables and flushes plus the PC enable/load.

## Interface
- No parameters; widths come from `cpu_types_pkg` (`word_t` = 32, `regbits_t` = 5).
- `CLK  in  1  system clock, rising edge`
- `RST  in  1  synchronous, active-high reset`
- `ihit  in  1  instruction fetch for current PC complete`
- `dhit  in  1  data access for MEM-stage instruction complete`
- `mem_req  in  1  MEM stage issues a data access (dREN_out_3 | dWEN_out_3)`
- `id_rs, id_rt  in  5 each  source registers of the instruction in ID (from instr_out_1)`
- `id_uses_rt  in  1  ID instruction reads rt (R-type, store, beq/bne)`
- `id_halt  in  1  ID instruction is HALT`
- `ex_dREN, ex_rt  in  1 / 5  EX stage holds a load and its destination (dREN_out_2, rt_out_2)`
- `mem_redirect  in  1  taken beq/bne, j, jal or JR resolved in MEM`
- `mem_target  in  32  redirect PC for mem_redirect`
- `wb_halt  in  1  halt_or_out_4`
- `pc_en  out  1  PC captures next sequential PC`
- `pc_load  out  1  PC loads pc_target (overrides pc_en)`
- `pc_target  out  32  redirect address, equals mem_target`
- `en_1..en_4  out  1 each  register bar n captures its inputs`
- `flush_1..flush_3  out  1 each  register bar n captures a bubble (all fields 0) when en_n is high`
- `halted  out  1  registered, sticky processor-halted flag`

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state: RUN.
- While RST is high: pc_en = pc_load = 0; en_1..en_4 = 1; flush_1..flush_3 = 1; halted = 0.
- Decisions in RUN apply in the priority order below; the first match wins.
  1. Freeze when `mem_req & !dhit`: pc_en, pc_load and en_1..en_4 = 0; no flush. This stalls everything, including a pending redirect, which reapplies next cycle.
  2. Redirect when `mem_redirect`: pc_load = 1; en_1..en_4 = 1; flush_1..flush_3 = 1, squashing the three younger instructions. A HALT in ID is squashed and the state stays RUN.
  3. Load-use stall when `ex_dREN & ex_rt != 0 & (ex_rt == id_rs | (id_uses_rt & ex_rt == id_rt))`: pc_en = en_1 = 0; en_2..en_4 = 1; flush_2 = 1.
  4. Halt on `id_halt`: pc_en = 0; en_1..en_4 = 1; flush_1 = 1; next state DRAIN.
  5. Fetch miss on `!ihit`: pc_en = 0; en_1..en_4 = 1; flush_1 = 1.
  6. Otherwise: pc_en = en_1..en_4 = 1; no flush.
- DRAIN: pc_en = 0; flush_1 = 1 every cycle.
  - Freeze (rule 1) and redirect (rule 2) apply as in RUN. A redirect returns the state to RUN, because an older branch squashed the HALT.
  - Move to HALTED when `wb_halt` is high and no freeze is active.
- HALTED: all enables, flushes, pc_load = 0; halted = 1. Only RST leaves this state.
- Asserting RST in any state, including mid-freeze or DRAIN, returns to RUN next cycle and clears halted.

## Timing
- All enable/flush/pc outputs are combinational from the state and current inputs, for same-cycle response. The state and halted are registered.
- HALT in ID at cycle t: DRAIN from t+1. wb_halt rises at t+3 when there are no freezes, and halted = 1 from t+4. Each freeze cycle adds one cycle.
- Load-use inserts exactly one bubble; the dependent instruction re-evaluates next cycle with the load in MEM.
- A redirect costs 3 squashed slots; the PC holds mem_target at the next edge.
- Simultaneous mem_redirect and freeze: freeze wins, and the redirect is applied on the dhit cycle.

## Configuration
- `PIPE_HAZARD_PERF_EN` defined:
  - Adds outputs `stall_cnt` (32) and `flush_cnt` (32), both reset to 0 and wrapping at 2^32.
  - stall_cnt increments in every RUN/DRAIN cycle where pc_en = 0 and pc_load = 0.
  - flush_cnt increments once per applied redirect.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- Reset: hold RST 2 cycles, then release with ihit = 1 and no hazards -> cycle 1: all en = 1, flushes 0, halted = 0.
- Load-use: ex_dREN = 1, ex_rt = 8, id_rs = 8 -> pc_en = 0, en_1 = 0, flush_2 = 1 for exactly 1 cycle. Repeat with ex_rt = 0 -> no stall.
- Redirect during freeze: mem_redirect = 1, mem_target = 0x0000_0040, mem_req = 1, dhit = 0 for 3 cycles -> en all 0 for 3 cycles. Then dhit = 1 -> pc_load = 1, pc_target = 0x40, flush_1..3 = 1.
- Halt drain: id_halt pulse at t, wb_halt at t+3 -> pc_en = 0 from t, halted = 1 at t+4 and stays 1 with all en = 0.
- Squashed halt: in DRAIN, assert mem_redirect -> state RUN, and halted remains 0 after wb_halt never arrives.
- Perf (`PIPE_HAZARD_PERF_EN`): 5 fetch-miss cycles plus 2 redirects -> stall_cnt = 5, flush_cnt = 2. Preload stall_cnt near 0xFFFF_FFFF and stall -> wraps to 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Drives the PC enable/load and the enable/bubble controls of the four
// pipeline register bars from cache status, load-use hazards, MEM-stage
// redirects and halt progress.
// Optional build macro PIPE_HAZARD_PERF_EN adds the stall_cnt/flush_cnt
// performance counters.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | normal issue; hazards resolved by priority each cycle
// DRAIN  | HALT accepted in ID, fetch stopped, waiting for it in WB
// HALTED | processor stopped; only RST leaves
module pipe_hazard_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_req,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_halt,
  input  logic        ex_dREN,
  input  logic [4:0]  ex_rt,
  input  logic        mem_redirect,
  input  logic [31:0] mem_target,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        en_1,
  output logic        en_2,
  output logic        en_3,
  output logic        en_4,
  output logic        flush_1,
  output logic        flush_2,
  output logic        flush_3,
  output logic        halted
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   halted_q;
  logic   freeze;
  logic   load_use;

  assign freeze   = mem_req & ~dhit;
  assign load_use = ex_dREN & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  assign pc_target = mem_target;
  assign halted    = halted_q;

  // Per-cycle enable/flush decisions and next state, first matching rule wins.
  always_comb begin
    state_d = state_q;
    pc_en   = 1'b0;
    pc_load = 1'b0;
    {en_1, en_2, en_3, en_4} = 4'b0000;
    {flush_1, flush_2, flush_3} = 3'b000;
    if (RST) begin
      {en_1, en_2, en_3, en_4} = 4'b1111;
      {flush_1, flush_2, flush_3} = 3'b111;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (freeze) begin
            // everything holds, including a pending redirect
          end else if (mem_redirect) begin
            pc_load = 1'b1;
            {en_1, en_2, en_3, en_4} = 4'b1111;
            {flush_1, flush_2, flush_3} = 3'b111;
          end else if (load_use) begin
            {en_2, en_3, en_4} = 3'b111;
            flush_2 = 1'b1;
          end else if (id_halt) begin
            {en_1, en_2, en_3, en_4} = 4'b1111;
            flush_1 = 1'b1;
            state_d = DRAIN;
          end else if (!ihit) begin
            {en_1, en_2, en_3, en_4} = 4'b1111;
            flush_1 = 1'b1;
          end else begin
            pc_en = 1'b1;
            {en_1, en_2, en_3, en_4} = 4'b1111;
          end
        end
        DRAIN: begin
          if (freeze) begin
            // hold; wb_halt is not accepted while frozen
          end else if (mem_redirect) begin
            // an older control transfer squashed the HALT
            pc_load = 1'b1;
            {en_1, en_2, en_3, en_4} = 4'b1111;
            {flush_1, flush_2, flush_3} = 3'b111;
            state_d = RUN;
          end else begin
            {en_1, en_2, en_3, en_4} = 4'b1111;
            flush_1 = 1'b1;
            if (wb_halt) state_d = HALTED;
          end
        end
        HALTED: state_d = HALTED;
        default: state_d = RUN;
      endcase
    end
  end

  // State and sticky halted flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALTED);
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Stall cycles (PC neither advancing nor loading) and applied redirects.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if ((state_q != HALTED) && !pc_en && !pc_load)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (pc_load)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a scoreboard of expected
// control vectors.
module tb_pipe_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST, ihit, dhit, mem_req;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_halt, ex_dREN, mem_redirect, wb_halt;
  logic [31:0] mem_target;
  logic        pc_en, pc_load, en_1, en_2, en_3, en_4;
  logic        flush_1, flush_2, flush_3, halted;
  logic [31:0] pc_target;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_halt(id_halt),
    .ex_dREN(ex_dREN), .ex_rt(ex_rt), .mem_redirect(mem_redirect),
    .mem_target(mem_target), .wb_halt(wb_halt),
    .pc_en(pc_en), .pc_load(pc_load), .pc_target(pc_target),
    .en_1(en_1), .en_2(en_2), .en_3(en_3), .en_4(en_4),
    .flush_1(flush_1), .flush_2(flush_2), .flush_3(flush_3),
    .halted(halted)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // {pc_en, pc_load, en_1..en_4, flush_1..flush_3, halted}
  localparam logic [9:0] V_RST    = 10'b0_0_1111_111_0;
  localparam logic [9:0] V_NORM   = 10'b1_0_1111_000_0;
  localparam logic [9:0] V_FRZ    = 10'b0_0_0000_000_0;
  localparam logic [9:0] V_REDIR  = 10'b0_1_1111_111_0;
  localparam logic [9:0] V_LU     = 10'b0_0_0111_010_0;
  localparam logic [9:0] V_BUB1   = 10'b0_0_1111_100_0;
  localparam logic [9:0] V_HALTED = 10'b0_0_0000_000_1;

  typedef struct packed {
    logic [9:0]  vec;
    logic [31:0] tgt;
  } exp_t;

  exp_t   sb_q[$];
  int     checks = 0;
  int     fails  = 0;

  task automatic idle();
    RST = 1'b0; ihit = 1'b1; dhit = 1'b0; mem_req = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_halt = 1'b0;
    ex_dREN = 1'b0; ex_rt = 5'd0; mem_redirect = 1'b0;
    mem_target = 32'h0000_1000; wb_halt = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push expectation for the inputs just driven, compare at negedge, advance one cycle.
  task automatic cyc(input logic [9:0] vec, input string tag);
    exp_t e, got;
    e.vec = vec;
    e.tgt = mem_target;
    sb_q.push_back(e);
    @(negedge CLK);
    got = sb_q.pop_front();
    check(tag, {22'd0, pc_en, pc_load, en_1, en_2, en_3, en_4,
                flush_1, flush_2, flush_3, halted}, {22'd0, got.vec});
    check({tag, "_tgt"}, pc_target, got.tgt);
    @(posedge CLK); #1;
  endtask

  task automatic skip();
    @(posedge CLK); #1;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    skip();
    cyc(V_RST, "reset");
    idle();
    cyc(V_NORM, "reset_release");

`ifdef PIPE_HAZARD_PERF_EN
    ihit = 1'b0;
    for (int i = 0; i < 5; i++) cyc(V_BUB1, "perf_miss");
    idle(); mem_redirect = 1'b1; mem_target = 32'h0000_0100;
    cyc(V_REDIR, "perf_redir_a");
    idle(); cyc(V_NORM, "perf_gap");
    mem_redirect = 1'b1; mem_target = 32'h0000_0200;
    cyc(V_REDIR, "perf_redir_b");
    idle();
    check("stall_cnt", stall_cnt, 32'd5);
    check("flush_cnt", flush_cnt, 32'd2);
`endif

    // load-use on rs: exactly one bubble, then the load has moved to MEM
    ex_dREN = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    cyc(V_LU, "lu_rs");
    idle(); id_rs = 5'd8;
    cyc(V_NORM, "lu_release");
    // rt dependence only counts when ID reads rt
    ex_dREN = 1'b1; ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
    cyc(V_LU, "lu_rt");
    id_uses_rt = 1'b0;
    cyc(V_NORM, "lu_rt_unused");
    // $zero destination never stalls
    idle(); ex_dREN = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    cyc(V_NORM, "lu_r0");

    // fetch miss
    idle(); ihit = 1'b0;
    cyc(V_BUB1, "fetch_miss");

    // redirect held by a data miss, applied on the dhit cycle
    idle(); mem_redirect = 1'b1; mem_target = 32'h0000_0040; mem_req = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) cyc(V_FRZ, "redir_frozen");
    dhit = 1'b1;
    cyc(V_REDIR, "redir_apply");
    idle();
    cyc(V_NORM, "after_redir");

    // load-use outranks halt; halt not accepted yet
    ex_dREN = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; id_halt = 1'b1;
    cyc(V_LU, "lu_over_halt");
    idle();
    cyc(V_NORM, "still_run");

    // redirect squashes HALT in ID; stays RUN
    mem_redirect = 1'b1; id_halt = 1'b1; mem_target = 32'h0000_0080;
    cyc(V_REDIR, "redir_over_halt");
    idle();
    cyc(V_NORM, "run_after_squash");

    // halt drain: id_halt at t, wb_halt at t+3, halted at t+4
    id_halt = 1'b1;
    cyc(V_BUB1, "halt_t0");
    idle(); ihit = 1'b1;
    cyc(V_BUB1, "drain_t1");
    cyc(V_BUB1, "drain_t2");
    wb_halt = 1'b1;
    cyc(V_BUB1, "drain_t3");
    idle();
    cyc(V_HALTED, "halted_t4");
    mem_redirect = 1'b1; ihit = 1'b1; id_halt = 1'b1;
    cyc(V_HALTED, "halted_sticky");
    idle(); RST = 1'b1;
    skip();
    cyc(V_RST, "reset_from_halted");
    idle();
    cyc(V_NORM, "run_after_halted");

    // drain with a freeze: wb_halt ignored while frozen
    id_halt = 1'b1;
    cyc(V_BUB1, "halt2_t0");
    idle();
    cyc(V_BUB1, "drain2_t1");
    mem_req = 1'b1; dhit = 1'b0; wb_halt = 1'b1;
    cyc(V_FRZ, "drain2_frozen");
    dhit = 1'b1;
    cyc(V_BUB1, "drain2_wb");
    idle();
    cyc(V_HALTED, "halted2");
    RST = 1'b1;
    skip();
    idle();
    cyc(V_NORM, "run_after_halted2");

    // squashed halt: redirect in DRAIN returns to RUN, never halts
    id_halt = 1'b1;
    cyc(V_BUB1, "halt3_t0");
    idle(); mem_redirect = 1'b1; mem_target = 32'h0000_00C0;
    cyc(V_REDIR, "drain_redirect");
    idle();
    for (int i = 0; i < 4; i++) cyc(V_NORM, "squashed_run");

    // reset mid-freeze
    mem_req = 1'b1; dhit = 1'b0; RST = 1'b1;
    cyc(V_RST, "reset_in_freeze");
    idle();
    cyc(V_NORM, "run_after_freeze_reset");

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
